// File: rtl/nn_pkg.sv
// Shared inference-datapath definitions: scanner state encoding, the class
// index width used by the arg-max stage and the label comparator, and the
// score ordering function.
// Build option: define ARGMAX_SIGNED_EN to order scores as two's-complement
// signed values; left undefined, scores are ordered as unsigned.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Class index width, common to the arg-max output and the label path
    localparam int CLASS_IDX_W = 8;

    // Widest score the ordering function handles; callers zero-extend into it
    localparam int SCORE_MAX_W = 32;

`ifdef ARGMAX_SIGNED_EN
    localparam bit SCORE_SIGNED = 1'b1;
`else
    localparam bit SCORE_SIGNED = 1'b0;
`endif

    // Strict a > b over scores of 'width' bits held zero-extended in the
    // low bits. Signed ordering flips the score's sign bit so that a plain
    // unsigned compare gives the two's-complement order.
    function automatic logic score_gt(
        input logic [SCORE_MAX_W-1:0] a,
        input logic [SCORE_MAX_W-1:0] b,
        input int                     width
    );
        logic [SCORE_MAX_W-1:0] bias;
        bias = SCORE_SIGNED ? (SCORE_MAX_W'(1) << (width - 1)) : '0;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/argmax_scanner.sv
// Sequential arg-max stage: scans NUM_CLASSES scores per frame, tracks the
// running maximum (first occurrence wins ties) and presents the winning
// class index and score, with a one-cycle out_valid pulse when a frame ends.
// Build option: ARGMAX_SIGNED_EN selects signed score ordering (see nn_pkg).
module argmax_scanner
    import nn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = CLASS_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max
);

    // One extra count bit keeps a 256-class frame from wrapping before DONE
    localparam logic [IDX_W:0] LAST_COUNT = (IDX_W+1)'(NUM_CLASSES - 1);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [IDX_W:0]     count;
    logic [DATA_W-1:0]  max_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               beat_accept;
    logic               new_max;

    assign beat_accept = in_valid && in_ready;
    assign new_max     = score_gt(SCORE_MAX_W'(in_data), SCORE_MAX_W'(max_reg), DATA_W);
    assign out_idx     = idx_reg;
    assign out_max     = max_reg;

    // State register; reset aborts any frame in flight without a result pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/status outputs decoded from the current state
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (beat_accept && (count == LAST_COUNT)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Beat counter and running maximum; results hold until the next first beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            max_reg <= '0;
            idx_reg <= '0;
        end else if ((state == IDLE) && start) begin
            count <= '0;
        end else if (beat_accept) begin
            count <= count + (IDX_W+1)'(1);
            if (count == '0) begin
                max_reg <= in_data;
                idx_reg <= '0;
            end else if (new_max) begin
                max_reg <= in_data;
                idx_reg <= count[IDX_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_argmax_scanner.sv
// Self-checking bench for argmax_scanner: a frame-level reference model
// (queue of accepted scores, arg-max recomputed by a plain loop) checked
// every cycle, plus hand-computed expectations for each directed frame.
module tb_argmax_scanner;

    localparam int DATA_W      = 8;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_max;

    int check_count = 0;
    int error_count = 0;

    argmax_scanner #(
        .DATA_W      (DATA_W),
        .NUM_CLASSES (NUM_CLASSES),
        .IDX_W       (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_max   (out_max)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Score ordering as stated for the build: signed or unsigned strict compare
    function automatic bit model_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Frame-level reference model: scanning/done flags and accepted-score queue
    bit                m_scan;
    bit                m_done;
    logic [DATA_W-1:0] m_beats[$];
    logic [IDX_W-1:0]  m_idx;
    logic [DATA_W-1:0] m_max;

    // Model update on each clock edge or reset assertion
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_scan = 1'b0;
            m_done = 1'b0;
            m_beats.delete();
            m_idx  = '0;
            m_max  = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_scan) begin
            if (start) begin
                m_scan = 1'b1;
                m_beats.delete();
            end
        end else if (in_valid) begin
            m_beats.push_back(in_data);
            m_idx = '0;
            m_max = m_beats[0];
            for (int k = 1; k < m_beats.size(); k++) begin
                if (model_gt(m_beats[k], m_max)) begin
                    m_max = m_beats[k];
                    m_idx = IDX_W'(k);
                end
            end
            if (m_beats.size() == NUM_CLASSES) begin
                m_scan = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        checkOutput("cyc_in_ready",  32'(in_ready),  32'(m_scan));
        checkOutput("cyc_busy",      32'(busy),      32'(m_scan || m_done));
        checkOutput("cyc_out_valid", 32'(out_valid), 32'(m_done));
        checkOutput("cyc_out_idx",   32'(out_idx),   32'(m_idx));
        checkOutput("cyc_out_max",   32'(out_max),   32'(m_max));
    end

    // Runs one frame from a negedge in IDLE; optional random stalls with start
    // pulses during SCAN. Ends on the first IDLE negedge after DONE.
    task automatic applyStimulus(
        input  logic [DATA_W-1:0] scores [NUM_CLASSES],
        input  bit                stall_mode,
        input  logic [IDX_W-1:0]  exp_idx,
        input  logic [DATA_W-1:0] exp_max,
        input  string             tag,
        output logic [IDX_W-1:0]  res_idx
    );
        int sent;
        int cycles;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        sent   = 0;
        cycles = 0;
        while (sent < NUM_CLASSES && cycles < 400) begin
            if (stall_mode && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
                start    = ($urandom_range(0, 1) == 1);
            end else begin
                in_valid = 1'b1;
                in_data  = scores[sent];
                start    = stall_mode && ($urandom_range(0, 3) == 0);
                sent++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (sent < NUM_CLASSES) begin
            checkOutput({tag, "_beats_sent"}, 32'(sent), 32'(NUM_CLASSES));
        end
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_out_idx"},   32'(out_idx),   32'(exp_idx));
        checkOutput({tag, "_out_max"},   32'(out_max),   32'(exp_max));
        res_idx = out_idx;
        @(negedge clk);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        logic [DATA_W-1:0] s_unique [NUM_CLASSES];
        logic [DATA_W-1:0] s_ties   [NUM_CLASSES];
        logic [DATA_W-1:0] s_sign   [NUM_CLASSES];
        logic [DATA_W-1:0] s_bb1    [NUM_CLASSES];
        logic [DATA_W-1:0] s_bb2    [NUM_CLASSES];
        logic [IDX_W-1:0]  res;
        logic [IDX_W-1:0]  label;
        logic [IDX_W-1:0]  sign_idx;
        logic [DATA_W-1:0] sign_max;

        s_unique = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd0, 8'd15, 8'd199, 8'd2, 8'd5};
        s_ties   = '{8'd50, 8'd80, 8'd80, 8'd10, 8'd80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        s_sign   = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        s_bb1    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd90, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        s_bb2    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
`ifdef ARGMAX_SIGNED_EN
        sign_idx = 8'd5;
        sign_max = 8'h7F;
`else
        sign_idx = 8'd2;
        sign_max = 8'h80;
`endif

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd0);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_idx",   32'(out_idx),   32'd0);
        checkOutput("reset_out_max",   32'(out_max),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset in the middle of a frame");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s_unique[i];
            @(negedge clk);
        end
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
        checkOutput("midrst_busy",      32'(busy),      32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_idx",   32'(out_idx),   32'd0);
        checkOutput("midrst_out_max",   32'(out_max),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] unique maximum");
        applyStimulus(s_unique, 1'b0, 8'd3, 8'd200, "unique", res);

        $display("[TB] ties keep first occurrence");
        applyStimulus(s_ties, 1'b0, 8'd1, 8'd80, "ties", res);

        $display("[TB] stalls with start pulses during scan");
        applyStimulus(s_unique, 1'b1, 8'd3, 8'd200, "stall", res);
        applyStimulus(s_ties, 1'b1, 8'd1, 8'd80, "stall_ties", res);

        $display("[TB] score signedness");
        applyStimulus(s_sign, 1'b0, sign_idx, sign_max, "sign", res);

        $display("[TB] back-to-back frames into label comparator");
        label = 8'd4;
        applyStimulus(s_bb1, 1'b0, 8'd4, 8'd90, "b2b_first", res);
        checkOutput("b2b_first_match", 32'(res == label), 32'd1);
        applyStimulus(s_bb2, 1'b0, 8'd9, 8'd100, "b2b_second", res);
        checkOutput("b2b_second_match", 32'(res == label), 32'd0);

        // Result must hold in IDLE after the frame
        repeat (3) @(negedge clk);
        checkOutput("hold_out_idx", 32'(out_idx), 32'd9);
        checkOutput("hold_out_max", 32'(out_max), 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
